uart_rx_ovs: RTL and testbench
==============================

Name: uart_rx_ovs

Overview:
Standalone UART receiver, 8N1, using 16x oversampling and a 3-sample majority vote. It is the receive end of the lab UART serial link: it deserialises the line driven by the transmitter, e.g. via the tx_o->rx_i loopback jumper. Received bytes are presented on a valid/ack handshake to the consuming logic (LED register, Wishbone UART wrapper). Framing errors and overruns are flagged.

Parameters:
OVS_DIV, 22, clk_i cycles per 1/16 bit tick (40 MHz / (22*16) = 113636 baud, -1.4% vs 115200)
DIV_W, 8, width of the tick divider counter; must satisfy 2**DIV_W > OVS_DIV

Ports:
clk_i  in  1  system clock, 40 MHz
rst_ni  in  1  asynchronous active-low reset
rx_i  in  1  serial line, idle high, asynchronous to clk_i
data_o  out  8  received byte, LSB first on the line
valid_o  out  1  data_o holds an unconsumed byte
ack_i  in  1  consumer takes data_o; only meaningful while valid_o=1
frame_err_o  out  1  one-cycle pulse: stop bit sampled 0
overrun_o  out  1  one-cycle pulse: byte completed while valid_o=1; new byte discarded
busy_o  out  1  receiver state is not IDLE

Behaviour:
- Reset (rst_ni=0, async): synchroniser flops=1, state=IDLE, all counters=0, data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
- Synchronisation: 2-FF synchroniser on rx_i gives rxs. All logic uses rxs only; rx_i to FSM latency is 2 cycles.
- Tick generator: div counter counts 0..OVS_DIV-1 and emits tick on OVS_DIV-1. It is held at 0 in IDLE and restarts at 0 on the start-edge cycle.
- Sample counter sc (4 bits) increments per tick and wraps 15->0. Samples are taken at sc=7,8,9. Bit value = majority of the 3 samples, resolved on the tick where sc=9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: on rxs 1->0 edge; sc=0.
  - START: at sc=9 resolve. Majority 1 -> IDLE (false start/glitch, no flags). Majority 0 -> continue; on sc wrap -> DATA, bit index=0.
  - DATA: resolve at sc=9 and shift into shift register MSB side (LSB first). After the wrap of bit index 7 -> STOP.
  - STOP: resolve at sc=9, then return to IDLE in the same cycle. The half stop bit is accepted so back-to-back frames are not missed.
- Byte completion happens in the STOP resolve cycle:
  - Majority 1 and valid_o=0: data_o<=shift, valid_o<=1 on the next edge.
  - Majority 1 and valid_o=1: overrun_o pulses 1 cycle; data_o and valid_o unchanged.
  - Majority 0: frame_err_o pulses 1 cycle and the byte is discarded (includes break, 0x00 + stop 0). Receiver returns to IDLE; a new start needs a fresh 1->0 edge, so a held-low break line yields exactly one frame_err.
- Handshake: valid_o falls the cycle after ack_i=1 while valid_o=1. If ack and completion coincide in the same cycle, the new byte is loaded, valid_o stays 1 and there is no overrun. ack_i while valid_o=0 is ignored.
- Latency: valid_o rises 1 cycle after the stop-bit sc=9 tick, i.e. about 9.5 bit times after the start edge plus 2 sync cycles.
- busy_o = (state != IDLE), registered.
- rx_i edges inside a frame are ignored except through sampling; no resync mid-frame.

Test Plan:
- Reset mid-frame: drive the start bit and 3 data bits of 0x55, assert rst_ni low for 5 cycles, release -> all outputs at reset values and busy_o=0. A subsequent clean 0x55 frame is received correctly.
- Single byte: frame 0x43, 352 cycles/bit -> valid_o=1, data_o=0x43, no flags. ack_i 1 cycle -> valid_o=0 the next cycle.
- Back-to-back with ack: 0x32, 0x22, 0xA5 with no idle gap, ack_i asserted within 100 cycles of each valid_o -> three bytes in order, no overrun_o.
- Overrun: two frames 0x11, 0x22 with no ack_i -> data_o=0x11, overrun_o single pulse at the second stop, valid_o still 1. Then ack and inject ack coincident with a third frame (0x33) completion -> data_o=0x33, valid_o=1, no overrun.
- Glitch and framing: 3-cycle low glitch on idle line -> busy_o briefly 1, then IDLE, no valid/flags. Frame 0x7E with stop=0 -> frame_err_o one pulse, valid_o=0. Line held low for 20 bit times -> exactly one frame_err_o.
- Baud tolerance: transmit 0x96 at bit periods of 340 and 364 cycles (±3.4%) -> data_o=0x96 correct in both cases.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 8N1 UART receiver with 16x oversampling and a 3-sample majority vote
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   rx_i         serial line, idle high, asynchronous to clk_i
//   data_o       last received byte
//   valid_o      data_o holds an unconsumed byte
//   ack_i        consumer takes data_o (ignored while valid_o=0)
//   frame_err_o  one-cycle pulse: stop bit sampled 0, byte dropped
//   overrun_o    one-cycle pulse: byte completed while valid_o=1, byte dropped
//   busy_o       receiver is inside a frame
module uart_rx_ovs #(
    parameter int OVS_DIV = 22,
    parameter int DIV_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ack_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    state_e           state_q, state_d;
    logic             sync_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sc_q, sc_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       smp_q, smp_d;
    logic [7:0]       shift_q, shift_d, data_q, data_d;
    logic             valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic             tick, resolve, wrap, maj;
    assign tick    = (state_q != IDLE) && (div_q == DIV_W'(OVS_DIV - 1));
    assign resolve = tick && (sc_q == 4'd9);
    assign wrap    = tick && (sc_q == 4'd15);
    // Third vote is the live sample taken on the sc=9 tick itself
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            div_q      <= '0;
            sc_q       <= '0;
            bit_q      <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= rx_i;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            div_q      <= div_d;
            sc_q       <= sc_d;
            bit_q      <= bit_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);
        sc_d    = tick ? sc_q + 4'd1 : sc_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~ack_i;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (tick && sc_q == 4'd7) smp_d[0] = rxs_q;
        if (tick && sc_q == 4'd8) smp_d[1] = rxs_q;
        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (rxs_prev_q && !rxs_q) state_d = START;
            end
            START: begin
                if (resolve && maj) begin
                    state_d = IDLE;
                    sc_d    = '0;
                end else if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (resolve) shift_d = {maj, shift_q[7:1]};
                if (wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave on the stop-bit resolve so a following start edge is not missed
                if (resolve) begin
                    state_d = IDLE;
                    sc_d    = '0;
                    if (!maj) ferr_d = 1'b1;
                    else if (valid_q && !ack_i) ovr_d = 1'b1;
                    else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed self-checking bench for uart_rx_ovs
`timescale 1ns/1ps
module tb_uart_rx_ovs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;

    uart_rx_ovs #(.OVS_DIV(22), .DIV_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_o(data), .valid_o(valid),
        .ack_i(ack), .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr) ovr_cnt++;
    end

    task automatic drive_bit(input logic v, input int per);
        rx = v;
        repeat (per) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int per, input logic stop);
        @(posedge clk);
        #1;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop, per);
        rx = 1'b1;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({data, valid, ferr, ovr, busy} !== 12'h000) begin
            err_cnt++;
            $display("FAIL reset_state: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0", data, valid, ferr, ovr, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
        @(posedge clk);
        #1;
        drive_bit(1'b0, 352);
        drive_bit(1'b1, 352);
        drive_bit(1'b0, 352);
        drive_bit(1'b1, 352);
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midframe_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({data, valid, ferr, ovr, busy} !== 12'h000) begin
            err_cnt++;
            $display("FAIL midframe_reset: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0", data, valid, ferr, ovr, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (400) @(negedge clk);
        vec_cnt++;
        if ({valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL after_release: v=%b busy=%b want 0 0", valid, busy);
        end
        send_byte(8'h55, 352, 1'b1);
        repeat (5) @(negedge clk);
        vec_cnt++;
        if ({valid, data} !== {1'b1, 8'h55}) begin
            err_cnt++;
            $display("FAIL reset_then_55: v=%b data=%h want 1 55", valid, data);
        end
        pulse_ack();
        @(negedge clk);
    endtask

    task automatic test_single();
        int f0 = ferr_cnt, o0 = ovr_cnt;
        send_byte(8'h43, 352, 1'b1);
        repeat (5) @(negedge clk);
        vec_cnt++;
        if ({valid, data} !== {1'b1, 8'h43}) begin
            err_cnt++;
            $display("FAIL single_43: v=%b data=%h want 1 43", valid, data);
        end
        vec_cnt++;
        if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
            err_cnt++;
            $display("FAIL single_flags: fe=%0d ov=%0d want 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        pulse_ack();
        @(negedge clk);
        vec_cnt++;
        if (valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_ack: v=%b want 0", valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3] = '{8'h32, 8'h22, 8'hA5};
        int o0 = ovr_cnt, f0 = ferr_cnt;
        fork
            for (int i = 0; i < 3; i++) send_byte(exp_b[i], 352, 1'b1);
            for (int i = 0; i < 3; i++) begin
                int n = 0;
                while (!valid && n < 6000) begin
                    @(negedge clk);
                    n++;
                end
                vec_cnt++;
                if (!valid) begin
                    err_cnt++;
                    $display("FAIL b2b_timeout[%0d]: valid=0 after %0d cycles want 1", i, n);
                end else if (data !== exp_b[i]) begin
                    err_cnt++;
                    $display("FAIL b2b_data[%0d]: data=%h want %h", i, data, exp_b[i]);
                end
                pulse_ack();
                @(negedge clk);
            end
        join
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (ovr_cnt - o0 != 0 || ferr_cnt - f0 != 0 || valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_flags: ov=%0d fe=%0d v=%b want 0 0 0", ovr_cnt - o0, ferr_cnt - f0, valid);
        end
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
        send_byte(8'h11, 352, 1'b1);
        send_byte(8'h22, 352, 1'b1);
        repeat (5) @(negedge clk);
        vec_cnt++;
        if ({valid, data} !== {1'b1, 8'h11} || ovr_cnt - o0 != 1) begin
            err_cnt++;
            $display("FAIL overrun: v=%b data=%h ov=%0d want 1 11 1", valid, data, ovr_cnt - o0);
        end
        o0 = ovr_cnt;
        // Stop-bit resolve falls 3391 edges after the start-bit drive edge
        fork
            send_byte(8'h33, 352, 1'b1);
            begin
                repeat (3391) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        vec_cnt++;
        if ({valid, data} !== {1'b1, 8'h33} || ovr_cnt - o0 != 0) begin
            err_cnt++;
            $display("FAIL ack_coincident: v=%b data=%h ov=%0d want 1 33 0", valid, data, ovr_cnt - o0);
        end
        pulse_ack();
        @(negedge clk);
    endtask

    task automatic test_glitch_framing();
        int f0 = ferr_cnt;
        int n = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL glitch_busy: busy=%b want 1", busy);
        end
        repeat (400) @(negedge clk);
        vec_cnt++;
        if ({busy, valid} !== 2'b00 || ferr_cnt != f0) begin
            err_cnt++;
            $display("FAIL glitch_idle: busy=%b v=%b fe=%0d want 0 0 0", busy, valid, ferr_cnt - f0);
        end
        send_byte(8'h7E, 352, 1'b0);
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (ferr_cnt - f0 != 1 || valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL frame_err: fe=%0d v=%b want 1 0", ferr_cnt - f0, valid);
        end
        f0 = ferr_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (20 * 352) @(posedge clk);
        #1 rx = 1'b1;
        repeat (400) @(negedge clk);
        vec_cnt++;
        if (ferr_cnt - f0 != 1 || valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL break: fe=%0d v=%b busy=%b want 1 0 0", ferr_cnt - f0, valid, busy);
        end
    endtask

    task automatic test_baud();
        int pers [2] = '{340, 364};
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h96, pers[i], 1'b1);
            repeat (5) @(negedge clk);
            vec_cnt++;
            if ({valid, data} !== {1'b1, 8'h96}) begin
                err_cnt++;
                $display("FAIL baud_%0d: v=%b data=%h want 1 96", pers[i], valid, data);
            end
            pulse_ack();
            repeat (50) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_glitch_framing();
        test_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
